mod_counter: RTL
================

# mod_counter

Parametrised modulo up/down counter for the VeriRISC datapath. It supersedes the fixed-function loadable counter and serves as the program counter, loop counter and timer. It adds configurable modulus, direction, per-cycle step size, a wrap or saturate mode, and a terminal-count flag. It is a single-clock block with all state registered.

## Interface

- WIDTH, 5, counter and data width in bits
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH
- RST_VAL, 0, value loaded on reset; must be < MODULUS
- SATURATE, 0, 0 = wrap modulo MODULUS, 1 = clamp at 0 / MODULUS-1

- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-low
- load  input  1  synchronous load of cnt_in
- enab  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- step  input  WIDTH  increment/decrement amount per enabled cycle
- cnt_in  input  WIDTH  load value
- cnt_out  output  WIDTH  registered count
- tc  output  1  registered terminal-count flag: overflow/underflow occurred on the last update
- zero  output  1  combinational, high when cnt_out == 0

## Operation

- Priority order: rst, then load, then enab, then hold.
- **Reset** (rst=0): cnt_out=RST_VAL and tc=0 immediately, with no clock edge needed. Reset holds while rst=0.
- **Load** (load=1, regardless of enab): cnt_out <= min(cnt_in, MODULUS-1) and tc <= 0.
- **Hold** (load=0, enab=0): cnt_out and tc keep their values. tc is held, not cleared.
- **Count** (load=0, enab=1): let s = min(step, MODULUS-1). All intermediate arithmetic is WIDTH+1 bits, so the sum never truncates.
  - Up, cnt+s <= MODULUS-1: next = cnt+s, tc=0.
  - Up, cnt+s > MODULUS-1: with SATURATE=0, next = cnt+s-MODULUS; with SATURATE=1, next = MODULUS-1. tc=1 in both cases.
  - Down, s <= cnt: next = cnt-s, tc=0.
  - Down, s > cnt: with SATURATE=0, next = cnt+MODULUS-s; with SATURATE=1, next = 0. tc=1 in both cases.
  - s=0: count unchanged, tc=0.
- Saturated counter pushed further in the same direction: value stays clamped and tc=1 again on every such cycle.
- Because s < MODULUS, a single update wraps at most once.
- With MODULUS == 2**WIDTH and SATURATE=0, the behaviour equals plain WIDTH-bit two's-complement wrap.

## Timing

- Latency: load and count take effect on the first rising clk edge after the inputs are set up. cnt_out and tc update on that same edge.
- zero follows cnt_out combinationally within the same cycle.
- Reset asserted mid-operation: outputs go to reset values asynchronously and override any load or enab in that cycle.
- Reset deassertion: the first edge with rst=1 performs a normal load, count or hold. The deassertion edge is synchronised externally.
- tc stays high only until the next load or enabled count clears it. It does not auto-clear during hold.
- Inputs must be stable around the rising edge. There is no handshake; enab is a qualifier, not a request.

## Test plan

Parameters WIDTH=5, MODULUS=20, RST_VAL=0 unless stated.

- **Async reset:** counter at 7; drop rst between clock edges -> cnt_out=0, tc=0, zero=1 before the next edge. Raise rst with enab=1, up=1, step=1 -> 1 after the next edge.
- **Load priority and clamp:** load=1, enab=1, cnt_in=0x0A -> 0x0A. Then cnt_in=0x15 -> 0x13. Then load=0, enab=0 for 2 cycles -> stays 0x13.
- **Wrap up/down (SATURATE=0):** load 18; up, step=3 -> 1 with tc=1. Step=1 -> 2 with tc=0. Load 1; down, step=3 -> 18 with tc=1. Step=0 -> 18 with tc=0.
- **Saturate (SATURATE=1):** load 18; up, step=3 -> 19 with tc=1. Repeat -> 19 with tc=1. Down, step=5 -> 14 with tc=0. Load 2; down, step=3 -> 0 with tc=1, zero=1.
- **Step clamp and full-range wrap:** MODULUS=20, load 5, up, step=0x1F -> 5+19-20=4 with tc=1. Second instance MODULUS=32: load 0x1F, up, step=1 -> 0x00 with tc=1.
- **Reset mid-count:** enab=1, up=1, step=2 running from 0. Assert rst after the count reaches 6 -> 0 immediately. Keep load=1 asserted during reset -> remains 0 until rst=1.

Source files
------------

// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter: the controller (master) drives
// load/enab/up/step/cnt_in and reads back the count and its flags.
interface mod_counter_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic             enab;
  logic             up;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cnt_in;
  logic [WIDTH-1:0] cnt_out;
  logic             tc;
  logic             zero;

  modport master (
    output load, enab, up, step, cnt_in,
    input  cnt_out, tc, zero
  );

  modport slave (
    input  load, enab, up, step, cnt_in,
    output cnt_out, tc, zero
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo up/down counter with configurable modulus, step size, wrap/saturate
// behaviour and a registered terminal-count flag.
module mod_counter #(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter int RST_VAL  = 0,
  parameter int SATURATE = 0
) (
  input logic         clk,
  input logic         rst,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   in_ext;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_cnt;
  logic             next_tc;

  // Arithmetic is one bit wider than the count so cnt+s never truncates;
  // since s < MODULUS a single update can cross the boundary at most once.
  always_comb begin
    cnt_ext  = {1'b0, cnt_q};
    step_ext = {1'b0, bus.step};
    in_ext   = {1'b0, bus.cnt_in};
    s        = (step_ext > MAX_W) ? MAX_W : step_ext;
    sum      = cnt_ext + s;
    load_val = (in_ext > MAX_W) ? MAX_W[WIDTH-1:0] : bus.cnt_in;
    next_cnt = cnt_q;
    next_tc  = 1'b0;
    if (bus.up) begin
      if (sum > MAX_W) begin
        next_tc  = 1'b1;
        next_cnt = SAT ? MAX_W[WIDTH-1:0] : WIDTH'(sum - MOD_W);
      end else begin
        next_cnt = WIDTH'(sum);
      end
    end else begin
      if (s > cnt_ext) begin
        next_tc  = 1'b1;
        next_cnt = SAT ? '0 : WIDTH'((cnt_ext + MOD_W) - s);
      end else begin
        next_cnt = WIDTH'(cnt_ext - s);
      end
    end
  end

  // tc is only rewritten by a load or an enabled count, so it survives holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_W;
      tc_q  <= 1'b0;
    end else if (bus.load) begin
      cnt_q <= load_val;
      tc_q  <= 1'b0;
    end else if (bus.enab) begin
      cnt_q <= next_cnt;
      tc_q  <= next_tc;
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.tc      = tc_q;
  assign bus.zero    = (cnt_q == '0);

endmodule
